// File: rtl/csr_bus_slave.sv
// CSR responder for the MAC config/status space: request/ack host bus, cfg_* outputs, clear-on-read frame counters.
// Optional build macro CSR_SCRATCH_EN maps a 32-bit RW scratch register at 0x18.
module csr_bus_slave #(
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter logic [47:0] MAC_ADDR_RST = 48'h001122334455
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic        bus_err,
    input  logic        tx_frame_done,
    input  logic        rx_frame_done,
    input  logic        rx_frame_err,
    output logic        cfg_tx_en,
    output logic        cfg_rx_en,
    output logic [1:0]  cfg_speed,
    output logic        cfg_full_duplex,
    output logic [47:0] cfg_mac_addr
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [5:0] W_CTRL   = 6'h00;
    localparam logic [5:0] W_MAC_LO = 6'h01;
    localparam logic [5:0] W_MAC_HI = 6'h02;
    localparam logic [5:0] W_TX     = 6'h03;
    localparam logic [5:0] W_RX     = 6'h04;
    localparam logic [5:0] W_RXERR  = 6'h05;
    localparam logic [5:0] W_SCR    = 6'h06;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  ctrl;
    logic [47:0] mac;
    logic [31:0] tx_cnt, rx_cnt, rx_err_cnt;
`ifdef CSR_SCRATCH_EN
    logic [31:0] scratch;
`endif
    logic [7:0]  rd_addr;
    logic [5:0]  rd_word, req_word;
    logic [31:0] rd_val;
    logic        rd_err;
    logic        commit, clr;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: if (bus_req) begin
                if (WAIT_CYCLES > 0) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 4'(WAIT_CYCLES);
                end else begin
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                if (!bus_req)           state_nxt = IDLE;
                else if (wait_cnt == 1) state_nxt = RESP;
                else                    wait_cnt_nxt = wait_cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With no wait states RESP is entered on the accepting edge, so decode the live address in IDLE.
    assign rd_addr  = (state == IDLE) ? bus_addr : req_addr;
    assign rd_word  = 6'(rd_addr >> 2);
    assign req_word = 6'(req_addr >> 2);

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        case (rd_word)
            W_CTRL:   rd_val = {27'd0, ctrl};
            W_MAC_LO: rd_val = mac[31:0];
            W_MAC_HI: rd_val = {16'd0, mac[47:32]};
            W_TX:     rd_val = tx_cnt;
            W_RX:     rd_val = rx_cnt;
            W_RXERR:  rd_val = rx_err_cnt;
`ifdef CSR_SCRATCH_EN
            W_SCR:    rd_val = scratch;
`endif
            default:  rd_err = 1'b1;
        endcase
    end

    assign bus_ack = (state == RESP);
    assign commit  = (state == RESP) &&  req_we;
    assign clr     = (state == RESP) && !req_we;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            bus_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == IDLE && bus_req) begin
                req_we    <= bus_we;
                req_addr  <= bus_addr;
                req_wdata <= bus_wdata;
            end
            bus_rdata <= (state_nxt == RESP) ? rd_val : '0;
            bus_err   <= (state_nxt == RESP) && rd_err;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            ctrl <= 5'h1B;
            mac  <= MAC_ADDR_RST;
`ifdef CSR_SCRATCH_EN
            scratch <= '0;
`endif
        end else if (commit) begin
            case (req_word)
                W_CTRL:   ctrl        <= req_wdata[4:0];
                W_MAC_LO: mac[31:0]   <= req_wdata;
                W_MAC_HI: mac[47:32]  <= req_wdata[15:0];
`ifdef CSR_SCRATCH_EN
                W_SCR:    scratch     <= req_wdata;
`endif
                default:  ;
            endcase
        end
    end

    // A pulse landing on the clear edge survives as a post-clear count of 1.
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            rx_err_cnt <= '0;
        end else begin
            if (clr && req_word == W_TX)              tx_cnt <= {31'd0, tx_frame_done};
            else if (tx_frame_done && tx_cnt != '1)   tx_cnt <= tx_cnt + 32'd1;
            if (clr && req_word == W_RX)              rx_cnt <= {31'd0, rx_frame_done};
            else if (rx_frame_done && rx_cnt != '1)   rx_cnt <= rx_cnt + 32'd1;
            if (clr && req_word == W_RXERR)           rx_err_cnt <= {31'd0, rx_frame_err};
            else if (rx_frame_err && rx_err_cnt != '1) rx_err_cnt <= rx_err_cnt + 32'd1;
        end
    end

    assign cfg_tx_en       = ctrl[0];
    assign cfg_rx_en       = ctrl[1];
    assign cfg_speed       = ctrl[3:2];
    assign cfg_full_duplex = ctrl[4];
    assign cfg_mac_addr    = mac;

endmodule

// File: tb/tb_csr_bus_slave.sv
// Bench for csr_bus_slave: one instance with no wait states, one with three.
// Table vectors, hand sequences for timing corners, and random traffic against an address-level model.
module tb_csr_bus_slave;

`ifdef CSR_SCRATCH_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rstn = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic tx_frame_done = 1'b0, rx_frame_done = 1'b0, rx_frame_err = 1'b0;
    logic        req [2];
    logic        we [2];
    logic [7:0]  addr [2];
    logic [31:0] wdata [2];
    logic        ack [2];
    logic [31:0] rdata [2];
    logic        err [2];
    logic        tx_en [2], rx_en [2], fd [2];
    logic [1:0]  speed [2];
    logic [47:0] mac [2];

    csr_bus_slave #(.WAIT_CYCLES(0)) dut0 (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn),
        .bus_req(req[0]), .bus_we(we[0]), .bus_addr(addr[0]), .bus_wdata(wdata[0]),
        .bus_ack(ack[0]), .bus_rdata(rdata[0]), .bus_err(err[0]),
        .tx_frame_done(tx_frame_done), .rx_frame_done(rx_frame_done), .rx_frame_err(rx_frame_err),
        .cfg_tx_en(tx_en[0]), .cfg_rx_en(rx_en[0]), .cfg_speed(speed[0]),
        .cfg_full_duplex(fd[0]), .cfg_mac_addr(mac[0])
    );

    csr_bus_slave #(.WAIT_CYCLES(3)) dut3 (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn),
        .bus_req(req[1]), .bus_we(we[1]), .bus_addr(addr[1]), .bus_wdata(wdata[1]),
        .bus_ack(ack[1]), .bus_rdata(rdata[1]), .bus_err(err[1]),
        .tx_frame_done(tx_frame_done), .rx_frame_done(rx_frame_done), .rx_frame_err(rx_frame_err),
        .cfg_tx_en(tx_en[1]), .cfg_rx_en(rx_en[1]), .cfg_speed(speed[1]),
        .cfg_full_duplex(fd[1]), .cfg_mac_addr(mac[1])
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of dut0, kept at the register-map level.
    logic [4:0]  m_ctrl;
    logic [47:0] m_mac;
    logic [31:0] m_scr;
    longint      m_cnt [3];

    task automatic m_reset();
        m_ctrl = 5'h1B;
        m_mac  = 48'h001122334455;
        m_scr  = '0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic m_access(input logic w, input logic [7:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic e);
        logic [7:0] wa;
        int idx;
        wa = a & 8'hFC;
        rd = '0;
        e  = 1'b0;
        case (wa)
            8'h00: if (w) m_ctrl = wd[4:0]; else rd = {27'd0, m_ctrl};
            8'h04: if (w) m_mac[31:0] = wd; else rd = m_mac[31:0];
            8'h08: if (w) m_mac[47:32] = wd[15:0]; else rd = {16'd0, m_mac[47:32]};
            8'h0C, 8'h10, 8'h14: begin
                idx = (int'(wa) - 12) / 4;
                if (!w) begin
                    rd = m_cnt[idx][31:0];
                    m_cnt[idx] = 0;
                end
            end
            8'h18: begin
                if (!SCR) e = 1'b1;
                else if (w) m_scr = wd;
                else rd = m_scr;
            end
            default: e = 1'b1;
        endcase
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_ctrl"}, {fd[0], speed[0], rx_en[0], tx_en[0]}, m_ctrl);
        check({tag, "_mac"}, mac[0], m_mac);
    endtask

    // Full host transaction; returns after the edge that ends the response cycle.
    task automatic xact(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        logic got;
        @(negedge sys_clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        got = 1'b0; lat = 0; rd = '0; e = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge sys_clk); #1;
            lat++;
            if (ack[d]) begin
                got = 1'b1; rd = rdata[d]; e = err[d];
            end
        end
        req[d] = 1'b0;
        check("ack_seen", got, 1'b1);
        @(posedge sys_clk); #1;
        check("ack_one_cycle", ack[d], 1'b0);
        check("rdata_zero_idle", rdata[d], 32'd0);
    endtask

    task automatic pulse(input logic t, input logic r, input logic e);
        @(negedge sys_clk);
        tx_frame_done = t; rx_frame_done = r; rx_frame_err = e;
        @(negedge sys_clk);
        tx_frame_done = 1'b0; rx_frame_done = 1'b0; rx_frame_err = 1'b0;
        if (t && m_cnt[0] < 64'hFFFF_FFFF) m_cnt[0]++;
        if (r && m_cnt[1] < 64'hFFFF_FFFF) m_cnt[1]++;
        if (e && m_cnt[2] < 64'hFFFF_FFFF) m_cnt[2]++;
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [4:0]  exp_ctrl;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [31:0] rd, mrd;
        logic        e, me;
        int          lat;
        logic        seen;
        logic [7:0]  alist [10];

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        m_reset();

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_ack", ack[0], 1'b0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_err", err[0], 1'b0);
        check_cfg("rst");
        @(negedge sys_clk);
        sys_rstn = 1'b1;

        vt.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 32'h0000001B, 1'b0, 5'h1B});
        vt.push_back('{1'b0, 8'h04, 32'h0,        1'b1, 32'h22334455, 1'b0, 5'h1B});
        vt.push_back('{1'b0, 8'h08, 32'h0,        1'b1, 32'h00000011, 1'b0, 5'h1B});
        vt.push_back('{1'b0, 8'h0C, 32'h0,        1'b1, 32'h00000000, 1'b0, 5'h1B});
        vt.push_back('{1'b0, 8'h14, 32'h0,        1'b1, 32'h00000000, 1'b0, 5'h1B});
        vt.push_back('{1'b1, 8'h00, 32'hFFFFFFE4, 1'b0, 32'h0,        1'b0, 5'h04});
        vt.push_back('{1'b0, 8'h00, 32'h0,        1'b1, 32'h00000004, 1'b0, 5'h04});
        vt.push_back('{1'b0, 8'h03, 32'h0,        1'b1, 32'h00000004, 1'b0, 5'h04});
        vt.push_back('{1'b1, 8'h3C, 32'h0000001F, 1'b0, 32'h0,        1'b1, 5'h04});
        vt.push_back('{1'b0, 8'h3C, 32'h0,        1'b1, 32'h00000000, 1'b1, 5'h04});
        vt.push_back('{1'b0, 8'h1C, 32'h0,        1'b1, 32'h00000000, 1'b1, 5'h04});
        vt.push_back('{1'b1, 8'h08, 32'hFFFFABCD, 1'b0, 32'h0,        1'b0, 5'h04});
        vt.push_back('{1'b0, 8'h08, 32'h0,        1'b1, 32'h0000ABCD, 1'b0, 5'h04});
        vt.push_back('{1'b1, 8'h0C, 32'h00000123, 1'b0, 32'h0,        1'b0, 5'h04});
        vt.push_back('{1'b0, 8'h0C, 32'h0,        1'b1, 32'h00000000, 1'b0, 5'h04});
        vt.push_back('{1'b1, 8'h18, 32'hA5A5A5A5, 1'b0, 32'h0,        !SCR, 5'h04});
        vt.push_back('{1'b0, 8'h18, 32'h0,        1'b1, SCR ? 32'hA5A5A5A5 : 32'h0, !SCR, 5'h04});
        vt.push_back('{1'b1, 8'h00, 32'h0000001B, 1'b0, 32'h0,        1'b0, 5'h1B});

        for (int i = 0; i < vt.size(); i++) begin
            xact(0, vt[i].we, vt[i].addr, vt[i].wdata, rd, e, lat);
            m_access(vt[i].we, vt[i].addr, vt[i].wdata, mrd, me);
            check($sformatf("vec%0d_lat", i), lat, 1);
            check($sformatf("vec%0d_err", i), e, vt[i].exp_err);
            if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d_ctrl", i), {fd[0], speed[0], rx_en[0], tx_en[0]}, vt[i].exp_ctrl);
        end
        check_cfg("table");

        // cfg outputs hold through the response cycle and change right after the commit edge
        @(negedge sys_clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h00; wdata[0] = 32'hFFFFFFE4;
        @(posedge sys_clk); #1;
        check("wr_ack_now", ack[0], 1'b1);
        req[0] = 1'b0;
        check("cfg_old_in_resp", {fd[0], speed[0], rx_en[0], tx_en[0]}, 5'h1B);
        @(posedge sys_clk); #1;
        check("cfg_new_tx", tx_en[0], 1'b0);
        check("cfg_new_rx", rx_en[0], 1'b0);
        check("cfg_new_speed", speed[0], 2'b01);
        check("cfg_new_fd", fd[0], 1'b0);
        m_access(1'b1, 8'h00, 32'hFFFFFFE4, mrd, me);

        // Counter: five pulses, clear-on-read, then a pulse on the clear edge
        repeat (5) pulse(1'b1, 1'b0, 1'b0);
        xact(0, 1'b0, 8'h0C, 32'h0, rd, e, lat);
        m_access(1'b0, 8'h0C, 32'h0, mrd, me);
        check("tx_cnt5", rd, 32'd5);
        xact(0, 1'b0, 8'h0C, 32'h0, rd, e, lat);
        m_access(1'b0, 8'h0C, 32'h0, mrd, me);
        check("tx_cnt_cleared", rd, 32'd0);
        @(negedge sys_clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h0C;
        @(posedge sys_clk); #1;
        check("coinc_ack", ack[0], 1'b1);
        check("coinc_rdata", rdata[0], 32'd0);
        req[0] = 1'b0;
        tx_frame_done = 1'b1;
        @(posedge sys_clk); #1;
        tx_frame_done = 1'b0;
        xact(0, 1'b0, 8'h0C, 32'h0, rd, e, lat);
        check("coinc_survives", rd, 32'd1);
        m_cnt[0] = 0;

        // Random traffic against the model
        alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h3C, 8'h0D};
        for (int n = 0; n < 150; n++) begin
            logic        rw;
            logic [7:0]  ra;
            logic [31:0] rwd;
            repeat ($urandom_range(0, 3))
                pulse(1'($urandom), 1'($urandom), 1'($urandom));
            rw  = 1'($urandom);
            ra  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : alist[$urandom_range(0, 9)];
            rwd = $urandom;
            xact(0, rw, ra, rwd, rd, e, lat);
            m_access(rw, ra, rwd, mrd, me);
            check($sformatf("rnd%0d_err@%0h", n, ra), e, me);
            if (!rw) check($sformatf("rnd%0d_rdata@%0h", n, ra), rd, mrd);
            if (n % 10 == 0) check_cfg($sformatf("rnd%0d", n));
        end
        check_cfg("rnd_end");

        // Three wait states: latency and abandoned request
        xact(1, 1'b0, 8'h00, 32'h0, rd, e, lat);
        check("w3_lat", lat, 4);
        check("w3_rdata", rd, 32'h1B);
        @(negedge sys_clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h04; wdata[1] = 32'hDEADBEEF;
        seen = 1'b0;
        repeat (2) begin @(posedge sys_clk); #1; seen |= ack[1]; end
        req[1] = 1'b0;
        repeat (6) begin @(posedge sys_clk); #1; seen |= ack[1]; end
        check("w3_drop_no_ack", seen, 1'b0);
        xact(1, 1'b0, 8'h04, 32'h0, rd, e, lat);
        check("w3_drop_no_commit", rd, 32'h22334455);

        // Reset during WAIT of a write to CTRL
        @(negedge sys_clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h00; wdata[1] = 32'h0;
        seen = 1'b0;
        repeat (2) begin @(posedge sys_clk); #1; seen |= ack[1]; end
        sys_rstn = 1'b0; req[1] = 1'b0;
        repeat (2) begin @(posedge sys_clk); #1; seen |= ack[1]; end
        @(negedge sys_clk);
        sys_rstn = 1'b1;
        repeat (5) begin @(posedge sys_clk); #1; seen |= ack[1]; end
        m_reset();
        check("rst_abort_no_ack", seen, 1'b0);
        check("rst_abort_ctrl", {fd[1], speed[1], rx_en[1], tx_en[1]}, 5'h1B);
        xact(1, 1'b0, 8'h00, 32'h0, rd, e, lat);
        check("rst_abort_rd_ctrl", rd, 32'h1B);

        // Saturation of RX_ERRORS
        @(negedge sys_clk);
        force dut3.rx_err_cnt = 32'hFFFFFFFF;
        @(negedge sys_clk);
        release dut3.rx_err_cnt;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        xact(1, 1'b0, 8'h14, 32'h0, rd, e, lat);
        check("rxerr_saturated", rd, 32'hFFFFFFFF);
        xact(1, 1'b0, 8'h14, 32'h0, rd, e, lat);
        check("rxerr_cleared", rd, 32'd0);
        xact(0, 1'b0, 8'h14, 32'h0, rd, e, lat);
        m_access(1'b0, 8'h14, 32'h0, mrd, me);
        check("dut0_rxerr", rd, mrd);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
